// File: rtl/aes_key_sched_if.sv
// Key-schedule bus: expansion request/status, shared S-box port and round-key read port.
interface aes_key_sched_if;
    logic         start;
    logic [1:0]   key_lenth;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         err;
    logic [31:0]  keyexp_sbox_in;
    logic [31:0]  keyexp_sbox_out;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_round;
    logic         rk_rd_inv;
    logic [127:0] rk_out;
    logic         rk_valid;

    modport master (
        output start, key_lenth, key_in, keyexp_sbox_out, rk_rd_en, rk_rd_round, rk_rd_inv,
        input  busy, done, err, keyexp_sbox_in, rk_out, rk_valid
    );
    modport slave (
        input  start, key_lenth, key_in, keyexp_sbox_out, rk_rd_en, rk_rd_round, rk_rd_inv,
        output busy, done, err, keyexp_sbox_in, rk_out, rk_valid
    );
endinterface

// File: rtl/aes_key_sched.sv
// AES key expansion (128/192/256) into a word store, one word per cycle, with round-key reads.
// Optional macro AES_KEY_SCHED_INVMIX_EN: InvMixColumns on inverse-order reads of middle rounds.
module aes_key_sched #(
    parameter int MAX_NK  = 8,
    parameter bit OUT_REG = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    aes_key_sched_if.slave io_ks
);
    localparam int DEPTH = 4 * (MAX_NK + 7);

    typedef enum logic {S_IDLE, S_EXP} state_t;
    state_t r_state, w_state_nxt;

    logic [31:0]  r_w [DEPTH];
    logic [3:0]   r_nk, r_nr;
    logic [5:0]   r_idx, r_t;
    logic [2:0]   r_mod;
    logic [7:0]   r_rcon;
    logic         r_key_valid, r_done, r_err, r_vld1;
    logic [127:0] r_dat1;

    logic [3:0]   w_nk_sel, w_rd_rnd;
    logic         w_len_ok, w_accept, w_reject, w_busy, w_last, w_rot_step, w_sub_only;
    logic         w_rd_acc, w_rd_zero;
    logic [31:0]  w_prev, w_back, w_temp, w_new, w_sbox_in;
    logic [127:0] w_rd_data;

    function automatic logic [7:0] f_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

`ifdef AES_KEY_SCHED_INVMIX_EN
    function automatic logic [7:0] f_mul(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) p = p ^ x;
            x = f_xt(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] f_inv_mix(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = c;
        return {f_mul(b0, 4'd14) ^ f_mul(b1, 4'd11) ^ f_mul(b2, 4'd13) ^ f_mul(b3, 4'd9),
                f_mul(b0, 4'd9)  ^ f_mul(b1, 4'd14) ^ f_mul(b2, 4'd11) ^ f_mul(b3, 4'd13),
                f_mul(b0, 4'd13) ^ f_mul(b1, 4'd9)  ^ f_mul(b2, 4'd14) ^ f_mul(b3, 4'd11),
                f_mul(b0, 4'd11) ^ f_mul(b1, 4'd13) ^ f_mul(b2, 4'd9)  ^ f_mul(b3, 4'd14)};
    endfunction
`endif

    always_comb begin
        case (io_ks.key_lenth)
            2'b00:   w_nk_sel = 4'd4;
            2'b01:   w_nk_sel = 4'd6;
            2'b10:   w_nk_sel = 4'd8;
            default: w_nk_sel = 4'd0;
        endcase
    end

    assign w_busy     = (r_state == S_EXP);
    assign w_len_ok   = (io_ks.key_lenth != 2'b11) && (w_nk_sel <= 4'(MAX_NK));
    assign w_accept   = !w_busy && io_ks.start && w_len_ok;
    assign w_reject   = !w_busy && io_ks.start && !w_len_ok;
    assign w_prev     = r_w[r_idx - 6'd1];
    assign w_back     = r_w[r_idx - {2'b00, r_nk}];
    assign w_rot_step = (r_mod == 3'd0);
    assign w_sub_only = (r_nk == 4'd8) && (r_mod == 3'd4);
    assign w_last     = (r_idx == r_t - 6'd1);

    // The shared S-box is only driven on steps that substitute; otherwise it sees zero.
    always_comb begin
        w_sbox_in = '0;
        w_temp    = w_prev;
        if (w_busy) begin
            if (w_rot_step) begin
                w_sbox_in = {w_prev[23:0], w_prev[31:24]};
                w_temp    = io_ks.keyexp_sbox_out ^ {r_rcon, 24'h0};
            end else if (w_sub_only) begin
                w_sbox_in = w_prev;
                w_temp    = io_ks.keyexp_sbox_out;
            end
        end
    end

    assign w_new = w_back ^ w_temp;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXP;
            S_EXP:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rcon      <= 8'h01;
            r_idx       <= '0;
            r_mod       <= '0;
            r_nk        <= 4'd4;
            r_nr        <= 4'd10;
            r_t         <= 6'd44;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_reject;
            if (w_accept) begin
                r_nk        <= w_nk_sel;
                r_nr        <= w_nk_sel + 4'd6;
                r_t         <= {w_nk_sel + 4'd7, 2'b00};
                r_idx       <= {2'b00, w_nk_sel};
                r_mod       <= '0;
                r_rcon      <= 8'h01;
                r_key_valid <= 1'b0;
            end else if (w_busy) begin
                r_idx <= r_idx + 6'd1;
                r_mod <= ({1'b0, r_mod} == r_nk - 4'd1) ? 3'd0 : r_mod + 3'd1;
                if (w_rot_step) r_rcon <= f_xt(r_rcon);
                if (w_last) begin
                    r_done      <= 1'b1;
                    r_key_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_accept) begin
            for (int j = 0; j < MAX_NK; j++)
                if (j < int'(w_nk_sel)) r_w[j] <= io_ks.key_in[255 - 32*j -: 32];
        end else if (rst_n && w_busy) begin
            r_w[r_idx] <= w_new;
        end
    end

    assign w_rd_acc  = io_ks.rk_rd_en && r_key_valid && !w_busy;
    assign w_rd_zero = (io_ks.rk_rd_round > r_nr);
    assign w_rd_rnd  = io_ks.rk_rd_inv ? r_nr - io_ks.rk_rd_round : io_ks.rk_rd_round;

    always_comb begin
        w_rd_data = '0;
        if (!w_rd_zero) begin
            w_rd_data = {r_w[{w_rd_rnd, 2'd0}], r_w[{w_rd_rnd, 2'd1}],
                         r_w[{w_rd_rnd, 2'd2}], r_w[{w_rd_rnd, 2'd3}]};
`ifdef AES_KEY_SCHED_INVMIX_EN
            if (io_ks.rk_rd_inv && (w_rd_rnd != 4'd0) && (w_rd_rnd != r_nr))
                w_rd_data = {f_inv_mix(w_rd_data[127:96]), f_inv_mix(w_rd_data[95:64]),
                             f_inv_mix(w_rd_data[63:32]),  f_inv_mix(w_rd_data[31:0])};
`endif
        end
    end

    // Read data only reloads on an accepted request so rk_out holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld1 <= 1'b0;
            r_dat1 <= '0;
        end else begin
            r_vld1 <= w_rd_acc;
            if (w_rd_acc) r_dat1 <= w_rd_data;
        end
    end

    generate
        if (OUT_REG) begin : g_oreg
            logic         r_vld2;
            logic [127:0] r_dat2;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_vld2 <= 1'b0;
                    r_dat2 <= '0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) r_dat2 <= r_dat1;
                end
            end
            assign io_ks.rk_valid = r_vld2;
            assign io_ks.rk_out   = r_dat2;
        end else begin : g_noreg
            assign io_ks.rk_valid = r_vld1;
            assign io_ks.rk_out   = r_dat1;
        end
    endgenerate

    assign io_ks.busy           = w_busy;
    assign io_ks.done           = r_done;
    assign io_ks.err            = r_err;
    assign io_ks.keyexp_sbox_in = w_sbox_in;
endmodule
